// File: rtl/romix_job_dispatch.sv
// Round-robin job dispatcher feeding the ROMix core array.
// Picks the next free core after the last one issued and fires a start strobe.
module romix_job_dispatch #(
    parameter int NUM_CORES = 32,
    parameter int IDX_W     = 5,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_nonce,
    input  logic [NUM_CORES-1:0] core_busy,
    output logic [NUM_CORES-1:0] core_start,
    output logic [DATA_W-1:0]    core_nonce,
    output logic [IDX_W-1:0]     core_idx,
    output logic                 all_busy,
    output logic [15:0]          dispatch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    scan_cnt;
    logic [DATA_W-1:0]   nonce_q;

    localparam logic [IDX_W-1:0]     LAST = IDX_W'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE  = {{(NUM_CORES-1){1'b0}}, 1'b1};

    // Explicit wrap so non-power-of-two core counts stay in range
    function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            core_start   <= '0;
            core_nonce   <= '0;
            core_idx     <= '0;
            all_busy     <= 1'b0;
            dispatch_cnt <= '0;
            ptr          <= LAST;
            cand         <= '0;
            scan_cnt     <= '0;
            nonce_q      <= '0;
        end else begin
            core_start <= '0;
            core_nonce <= '0;
            core_idx   <= '0;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        nonce_q  <= in_nonce;
                        cand     <= inc(ptr);
                        scan_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!core_busy[cand]) begin
                        core_start   <= ONE << cand;
                        core_nonce   <= nonce_q;
                        core_idx     <= cand;
                        ptr          <= cand;
                        dispatch_cnt <= dispatch_cnt + 16'd1;
                        all_busy     <= 1'b0;
                        state        <= ISSUE;
                    end else begin
                        cand <= inc(cand);
                        if (scan_cnt == LAST) begin
                            all_busy <= 1'b1;
                            scan_cnt <= '0;
                        end else begin
                            scan_cnt <= scan_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_romix_job_dispatch.sv
// Directed bench for romix_job_dispatch.
// Cores are modelled as going busy the cycle after their start strobe.
module tb_romix_job_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_nonce = '0;
    logic [31:0] core_busy;
    logic [31:0] core_start;
    logic [31:0] core_nonce;
    logic [4:0]  core_idx;
    logic        all_busy;
    logic [15:0] dispatch_cnt;

    logic [31:0] busy_auto = '0;
    logic [31:0] busy_hold = '0;
    logic        sticky = 1'b0;
    logic        tb_clr = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    romix_job_dispatch dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_nonce     (in_nonce),
        .core_busy    (core_busy),
        .core_start   (core_start),
        .core_nonce   (core_nonce),
        .core_idx     (core_idx),
        .all_busy     (all_busy),
        .dispatch_cnt (dispatch_cnt)
    );

    always #5 clk = ~clk;

    // sticky: core stays busy once started; otherwise busy for one cycle only
    always @(posedge clk) begin
        if (tb_clr)
            busy_auto <= '0;
        else
            busy_auto <= sticky ? (busy_auto | core_start) : core_start;
    end

    assign core_busy = busy_auto | busy_hold;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tb_clr    = 1'b1;
        busy_hold = '0;
        in_valid  = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        tb_clr = 1'b0;
    endtask

    task automatic handshake(input logic [31:0] n);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_nonce = n;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 1;
        while (core_start == 0 && lat < 100) begin
            tick();
            lat++;
        end
        if (core_start == 0) check("start_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int k;
        int g;
        int last;
        int starts;
        int rise;

        // 1: reset values and single job
        do_reset();
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_start", core_start, 32'd0);
        check("rst_idx", {27'd0, core_idx}, 32'd0);
        check("rst_nonce", core_nonce, 32'd0);
        check("rst_allbusy", {31'd0, all_busy}, 32'd0);
        check("rst_cnt", {16'd0, dispatch_cnt}, 32'd0);
        handshake(32'hDEADBEEF);
        wait_start(lat);
        check("j1_lat", lat, 32'd2);
        check("j1_start", core_start, 32'h1);
        check("j1_idx", {27'd0, core_idx}, 32'd0);
        check("j1_nonce", core_nonce, 32'hDEADBEEF);
        check("j1_cnt", {16'd0, dispatch_cnt}, 32'd1);
        tick();
        check("j1_ready", {31'd0, in_ready}, 32'd1);
        check("j1_clr_start", core_start, 32'd0);
        check("j1_clr_nonce", core_nonce, 32'd0);

        // 2: four back-to-back jobs, in_valid held
        do_reset();
        sticky   = 1'b1;
        in_nonce = 32'h100;
        in_valid = 1'b1;
        k = 0;
        g = 0;
        last = 0;
        while (k < 4 && g < 60) begin
            tick();
            g++;
            if (core_start != 0) begin
                check("b2b_idx", {27'd0, core_idx}, k);
                check("b2b_start", core_start, 32'h1 << k);
                check("b2b_nonce", core_nonce, 32'h100 + k);
                if (k > 0) check("b2b_gap", cyc - last, 32'd3);
                last = cyc;
                k++;
                in_nonce = 32'h100 + k;
                if (k == 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_jobs", k, 32'd4);
        check("b2b_cnt", {16'd0, dispatch_cnt}, 32'd4);

        // 3: skip busy cores 1..3
        do_reset();
        sticky = 1'b1;
        handshake(32'hA0);
        wait_start(lat);
        check("skip_first_idx", {27'd0, core_idx}, 32'd0);
        tick();
        busy_hold = 32'h0000_000E;
        handshake(32'hA1);
        wait_start(lat);
        check("skip_lat", lat, 32'd5);
        check("skip_idx", {27'd0, core_idx}, 32'd4);
        check("skip_start", core_start, 32'h10);
        busy_hold = '0;

        // 4: all busy, core 7 frees 40 cycles after handshake
        do_reset();
        sticky    = 1'b0;
        busy_hold = '1;
        handshake(32'hC7);
        lat  = 1;
        rise = 0;
        while (core_start == 0 && lat < 80) begin
            if (all_busy && rise == 0) rise = lat;
            if (lat == 40) begin
                check("ab_before_free", {31'd0, all_busy}, 32'd1);
                busy_hold[7] = 1'b0;
            end
            tick();
            lat++;
        end
        check("ab_rise", rise, 32'd33);
        check("ab_lat", lat, 32'd41);
        check("ab_start", core_start, 32'h80);
        check("ab_idx", {27'd0, core_idx}, 32'd7);
        check("ab_clear", {31'd0, all_busy}, 32'd0);
        busy_hold = '0;

        // 5: pointer wrap and counter wrap
        do_reset();
        sticky = 1'b0;
        for (int i = 0; i < 32; i++) begin
            handshake(32'h5000 + i);
            wait_start(lat);
            check("wrap_seq_idx", {27'd0, core_idx}, i);
        end
        handshake(32'h5020);
        wait_start(lat);
        check("wrap_idx", {27'd0, core_idx}, 32'd0);
        check("wrap_cnt", {16'd0, dispatch_cnt}, 32'd33);
        tick();
        force dut.dispatch_cnt = 16'hFFFF;
        tick();
        release dut.dispatch_cnt;
        tick();
        check("cnt_preset", {16'd0, dispatch_cnt}, 32'hFFFF);
        handshake(32'h5021);
        wait_start(lat);
        check("cnt_wrap", {16'd0, dispatch_cnt}, 32'd0);
        check("cnt_wrap_idx", {27'd0, core_idx}, 32'd1);

        // 6: reset during all-busy scan
        do_reset();
        busy_hold = '1;
        handshake(32'h66);
        g = 0;
        while (!all_busy && g < 60) begin
            tick();
            g++;
        end
        check("rs_allbusy", {31'd0, all_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_ready", {31'd0, in_ready}, 32'd1);
        check("rs_allbusy_clr", {31'd0, all_busy}, 32'd0);
        check("rs_cnt", {16'd0, dispatch_cnt}, 32'd0);
        busy_hold = '0;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_start != 0) starts++;
            tick();
        end
        check("rs_nostart", starts, 32'd0);
        handshake(32'h77);
        wait_start(lat);
        check("rs_next_idx", {27'd0, core_idx}, 32'd0);
        check("rs_next_nonce", core_nonce, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
